// File: rtl/fifo_rr_pkg.sv
// rtl/fifo_rr_pkg.sv - width helpers and lane-selector wrap function for the round-robin FIFO bank
package fifo_rr_pkg;

    function automatic int lsel_w(input int num_lanes);
        int w;
        w = $clog2(num_lanes);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int next_sel(input int sel, input int n);
        return (sel >= n - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_lane.sv
// rtl/fifo_rr_lane.sv - single circular-buffer lane with occupancy counter, flags and head output
module fifo_rr_lane
    import fifo_rr_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once the counter is zero.
    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fifo_rr_bank.sv
// rtl/fifo_rr_bank.sv - order-preserving FIFO striped round-robin across NUM_LANES lane FIFOs
module fifo_rr_bank
    import fifo_rr_pkg::*;
#(
    parameter int WIDTH     = 96,
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 1
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   in_enq__ENA,
    input  logic [WIDTH-1:0]                       in_enq_v,
    output logic                                   in_enq__RDY,
    input  logic                                   out_deq__ENA,
    output logic                                   out_deq__RDY,
    output logic [WIDTH-1:0]                       out_first,
    output logic                                   out_first__RDY,
    input  logic                                   clear__ENA,
    output logic [$clog2(NUM_LANES*DEPTH+1)-1:0]   count
);

    localparam int LSEL_W = lsel_w(NUM_LANES);
    localparam int CNT_W  = $clog2(NUM_LANES * DEPTH + 1);

    logic [LSEL_W-1:0]    r_wr_sel;
    logic [LSEL_W-1:0]    r_rd_sel;
    logic [CNT_W-1:0]     r_count;
    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_push;
    logic [NUM_LANES-1:0] w_pop;
    logic [WIDTH-1:0]     w_head [NUM_LANES];
    logic                 w_enq_rdy;
    logic                 w_deq_rdy;
    logic [WIDTH-1:0]     w_first;
    logic                 w_enq_fire;
    logic                 w_deq_fire;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_push[g] = w_enq_fire && (r_wr_sel == LSEL_W'(g));
        assign w_pop[g]  = w_deq_fire && (r_rd_sel == LSEL_W'(g));

        fifo_rr_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .CLK     (CLK),
            .RST     (RST),
            .i_clear (clear__ENA),
            .i_push  (w_push[g]),
            .i_data  (in_enq_v),
            .i_pop   (w_pop[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );
    end

    // AND-OR selection keeps out_first at zero whenever the selected lane is empty.
    always_comb begin
        w_enq_rdy = 1'b0;
        w_deq_rdy = 1'b0;
        w_first   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_enq_rdy = w_enq_rdy | ((r_wr_sel == LSEL_W'(i)) && !w_full[i]);
            w_deq_rdy = w_deq_rdy | ((r_rd_sel == LSEL_W'(i)) && !w_empty[i]);
            w_first   = w_first | (w_head[i] & {WIDTH{(r_rd_sel == LSEL_W'(i)) && !w_empty[i]}});
        end
    end

    assign w_enq_fire = in_enq__ENA && w_enq_rdy;
    assign w_deq_fire = out_deq__ENA && w_deq_rdy;

    always_ff @(posedge CLK) begin
        if (RST || clear__ENA) begin
            r_wr_sel <= '0;
            r_rd_sel <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) r_wr_sel <= LSEL_W'(next_sel(int'(r_wr_sel), NUM_LANES));
            if (w_deq_fire) r_rd_sel <= LSEL_W'(next_sel(int'(r_rd_sel), NUM_LANES));
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_enq__RDY    = w_enq_rdy;
    assign out_deq__RDY   = w_deq_rdy;
    assign out_first__RDY = w_deq_rdy;
    assign out_first      = w_first;
    assign count          = r_count;

endmodule

// File: tb/tb_fifo_rr_bank.sv
// tb/tb_fifo_rr_bank.sv - scoreboard bench for fifo_rr_bank across three lane/depth configurations
module tb_fifo_rr_bank;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enq [3];
    logic        deq [3];
    logic        clr [3];
    logic [95:0] din [3];

    logic        a_enq_rdy, a_deq_rdy, a_first_rdy;
    logic [95:0] a_first;
    logic [1:0]  a_count;
    logic        b_enq_rdy, b_deq_rdy, b_first_rdy;
    logic [95:0] b_first;
    logic [3:0]  b_count;
    logic        c_enq_rdy, c_deq_rdy, c_first_rdy;
    logic [95:0] c_first;
    logic [2:0]  c_count;

    logic [95:0] sb [$];
    int          cap [3];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 CLK = ~CLK;

    fifo_rr_bank #(.WIDTH(96), .NUM_LANES(2), .DEPTH(1)) u_a (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq[0]), .in_enq_v(din[0]), .in_enq__RDY(a_enq_rdy),
        .out_deq__ENA(deq[0]), .out_deq__RDY(a_deq_rdy),
        .out_first(a_first), .out_first__RDY(a_first_rdy),
        .clear__ENA(clr[0]), .count(a_count)
    );

    fifo_rr_bank #(.WIDTH(96), .NUM_LANES(3), .DEPTH(4)) u_b (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq[1]), .in_enq_v(din[1]), .in_enq__RDY(b_enq_rdy),
        .out_deq__ENA(deq[1]), .out_deq__RDY(b_deq_rdy),
        .out_first(b_first), .out_first__RDY(b_first_rdy),
        .clear__ENA(clr[1]), .count(b_count)
    );

    fifo_rr_bank #(.WIDTH(96), .NUM_LANES(3), .DEPTH(2)) u_c (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq[2]), .in_enq_v(din[2]), .in_enq__RDY(c_enq_rdy),
        .out_deq__ENA(deq[2]), .out_deq__RDY(c_deq_rdy),
        .out_first(c_first), .out_first__RDY(c_first_rdy),
        .clear__ENA(clr[2]), .count(c_count)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic sample(input int k, output logic er, output logic dr, output logic fr,
                          output logic [95:0] f, output int cnt);
        case (k)
            0: begin er = a_enq_rdy; dr = a_deq_rdy; fr = a_first_rdy; f = a_first; cnt = int'(a_count); end
            1: begin er = b_enq_rdy; dr = b_deq_rdy; fr = b_first_rdy; f = b_first; cnt = int'(b_count); end
            default: begin er = c_enq_rdy; dr = c_deq_rdy; fr = c_first_rdy; f = c_first; cnt = int'(c_count); end
        endcase
    endtask

    // Compare instance k against the model, advance the model with this cycle's stimulus, then clock.
    task automatic step(input int k);
        logic        er, dr, fr;
        logic [95:0] f;
        logic [95:0] exp_v;
        int          cnt;
        bit          nonempty;
        bit          do_enq;
        sample(k, er, dr, fr, f, cnt);
        nonempty = (sb.size() > 0);
        do_enq   = enq[k] && (sb.size() < cap[k]);
        check_eq("enq_rdy", 96'(er), 96'(sb.size() < cap[k]));
        check_eq("deq_rdy", 96'(dr), 96'(nonempty));
        check_eq("first_rdy", 96'(fr), 96'(nonempty));
        check_eq("count", 96'(cnt), 96'(sb.size()));
        if (!nonempty) begin
            check_eq("first_zero", f, '0);
        end else if (deq[k] && !clr[k] && !RST) begin
            exp_v = sb.pop_front();
            check_eq("deq_data", f, exp_v);
        end else begin
            check_eq("head", f, sb[0]);
        end
        if (RST || clr[k]) sb.delete();
        else if (do_enq) sb.push_back(din[k]);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        cap = '{2, 12, 6};
        for (int i = 0; i < 3; i++) begin
            enq[i] = 1'b0; deq[i] = 1'b0; clr[i] = 1'b0; din[i] = '0;
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();

        // ping-pong config: A,B accepted, C stalls, then drained in order
        enq[0] = 1'b1;
        din[0] = 96'hA00000000000000000000A01; step(0);
        din[0] = 96'hB00000000000000000000B02; step(0);
        din[0] = 96'hC00000000000000000000C03; step(0);
        deq[0] = 1'b1;
        step(0);
        step(0);
        enq[0] = 1'b0;
        step(0);
        step(0);
        deq[0] = 1'b0;

        // 3 lanes x 4 deep: fill, overfill attempt, drain, underflow attempt
        enq[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din[1] = 96'(i);
            step(1);
        end
        din[1] = 96'd99;
        step(1);
        enq[1] = 1'b0;
        deq[1] = 1'b1;
        repeat (13) step(1);
        deq[1] = 1'b0;

        // clear with a concurrent enqueue at count=5
        enq[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din[1] = 96'(100 + i);
            step(1);
        end
        clr[1] = 1'b1;
        din[1] = 96'h77;
        step(1);
        clr[1] = 1'b0;
        enq[1] = 1'b0;
        step(1);
        enq[1] = 1'b1;
        din[1] = 96'h55;
        step(1);
        enq[1] = 1'b0;
        step(1);
        deq[1] = 1'b1;
        step(1);
        deq[1] = 1'b0;
        step(1);

        // 3 lanes x 2 deep: random traffic
        for (int n = 0; n < 10000; n++) begin
            enq[2] = 1'($urandom_range(0, 1));
            deq[2] = 1'($urandom_range(0, 1));
            din[2] = {$urandom, $urandom, $urandom};
            step(2);
        end
        enq[2] = 1'b0;
        deq[2] = 1'b1;
        repeat (8) step(2);
        deq[2] = 1'b0;

        // reset mid-stream with dequeue asserted
        enq[0] = 1'b1;
        deq[0] = 1'b1;
        din[0] = 96'h1; step(0);
        din[0] = 96'h2; step(0);
        RST = 1'b1;
        din[0] = 96'h3; step(0);
        RST = 1'b0;
        enq[0] = 1'b0;
        deq[0] = 1'b0;
        step(0);
        enq[0] = 1'b1;
        din[0] = 96'hAB; step(0);
        din[0] = 96'hCD; step(0);
        enq[0] = 1'b0;
        deq[0] = 1'b1;
        step(0);
        step(0);
        step(0);
        deq[0] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
